time_redundant_issue: RTL and testbench



---
 rtl/time_redundant_issue_if.sv | 39 +++
 rtl/time_redundant_issue.sv | 108 ++++++++++
 tb/tb_time_redundant_issue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/time_redundant_issue_if.sv
// +-----------------------------------------------------------------------------+
// | time_redundant_issue_if                                                     |
// | Arbiter-side and voter-side signals of the replication issue stage.         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface time_redundant_issue_if #(
    parameter int DataWidth = 32,
    parameter int IdxWidth  = 2,
    parameter int CopyWidth = 2,
    parameter int IdWidth   = 4
);
    logic                 flush_i;
    logic                 valid_i;
    logic                 ready_o;
    logic [DataWidth-1:0] data_i;
    logic [IdxWidth-1:0]  idx_i;
    logic                 lock_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [DataWidth-1:0] data_o;
    logic [IdxWidth-1:0]  idx_o;
    logic [CopyWidth-1:0] copy_o;
    logic [IdWidth-1:0]   id_o;
    logic                 busy_o;

    modport master (
        output flush_i, valid_i, data_i, idx_i, ready_i,
        input  ready_o, lock_o, valid_o, data_o, idx_o, copy_o, id_o, busy_o
    );

    modport slave (
        input  flush_i, valid_i, data_i, idx_i, ready_i,
        output ready_o, lock_o, valid_o, data_o, idx_o, copy_o, id_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/time_redundant_issue.sv
// +-----------------------------------------------------------------------------+
// | time_redundant_issue                                                        |
// | Buffers one arbitrated item and reissues it Repl times with copy/id tags.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module time_redundant_issue #(
    parameter int DataWidth = 32,
    parameter int NumIn     = 4,
    parameter int IdxWidth  = (NumIn > 1) ? $clog2(NumIn) : 1,
    parameter int Repl      = 3,
    parameter int CopyWidth = $clog2(Repl),
    parameter int IdWidth   = 4
) (
    input  wire                   clk_i,
    input  wire                   rst_i,
    time_redundant_issue_if.slave bus
);

    if (!(Repl == 2 || Repl == 3)) begin : g_repl_check
        $fatal(1, "time_redundant_issue: Repl must be 2 or 3");
    end

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CopyWidth-1:0] copy_q, copy_d;
    logic [IdWidth-1:0]   id_cnt_q, id_cnt_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [IdxWidth-1:0]  idx_q, idx_d;
    logic [IdWidth-1:0]   id_q, id_d;

    logic last_copy;
    logic ready;
    logic accept;

    always_comb begin
        state_d  = state_q;
        copy_d   = copy_q;
        id_cnt_d = id_cnt_q;
        data_d   = data_q;
        idx_d    = idx_q;
        id_d     = id_q;

        last_copy = (copy_q == CopyWidth'(Repl - 1));
        // Last-copy handshake frees the buffer, so a new item may load in the same cycle.
        ready  = !rst_i && !bus.flush_i &&
                 ((state_q == ST_IDLE) || (bus.ready_i && last_copy));
        accept = bus.valid_i && ready;

        if (bus.flush_i) begin
            state_d  = ST_IDLE;
            copy_d   = '0;
            id_cnt_d = '0;
        end else if (accept) begin
            state_d  = ST_ISSUE;
            copy_d   = '0;
            data_d   = bus.data_i;
            idx_d    = bus.idx_i;
            id_d     = id_cnt_q;
            id_cnt_d = id_cnt_q + IdWidth'(1);
        end else if ((state_q == ST_ISSUE) && bus.ready_i) begin
            if (last_copy) begin
                state_d = ST_IDLE;
                copy_d  = '0;
            end else begin
                copy_d = copy_q + CopyWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            copy_q   <= '0;
            id_cnt_q <= '0;
            data_q   <= '0;
            idx_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            copy_q   <= copy_d;
            id_cnt_q <= id_cnt_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
            id_q     <= id_d;
        end
    end

    // Outputs are forced to their reset values while reset is held, not only after it.
    always_comb begin
        bus.ready_o = ready;
        bus.lock_o  = !rst_i && ((state_q == ST_ISSUE) || accept);
        bus.valid_o = !rst_i && (state_q == ST_ISSUE);
        bus.busy_o  = !rst_i && (state_q == ST_ISSUE);
        bus.copy_o  = rst_i ? '0 : copy_q;
        bus.data_o  = rst_i ? '0 : data_q;
        bus.idx_o   = rst_i ? '0 : idx_q;
        bus.id_o    = rst_i ? '0 : id_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_time_redundant_issue.sv
// +-----------------------------------------------------------------------------+
// | tb_time_redundant_issue                                                     |
// | Directed self-checking bench for time_redundant_issue (Repl=3, IdWidth=4).  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_time_redundant_issue;

    localparam int DW = 32;
    localparam int IW = 2;
    localparam int CW = 2;
    localparam int DI = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    time_redundant_issue_if #(.DataWidth(DW), .IdxWidth(IW), .CopyWidth(CW), .IdWidth(DI)) bus ();

    time_redundant_issue #(
        .DataWidth(DW),
        .NumIn    (4),
        .Repl     (3),
        .IdWidth  (DI)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input bit v, input int cp, input int id,
                           input int idx, input logic [31:0] d, input bit lk, input bit rdy);
        chk({tag, ".valid"}, 32'(bus.valid_o), 32'(v));
        chk({tag, ".busy"},  32'(bus.busy_o),  32'(v));
        chk({tag, ".copy"},  32'(bus.copy_o),  cp);
        chk({tag, ".id"},    32'(bus.id_o),    id);
        chk({tag, ".idx"},   32'(bus.idx_o),   idx);
        chk({tag, ".data"},  bus.data_o,       d);
        chk({tag, ".lock"},  32'(bus.lock_o),  32'(lk));
        chk({tag, ".ready"}, 32'(bus.ready_o), 32'(rdy));
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] d, input int idx);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.idx_i   = 2'(idx);
    endtask

    // Back-to-back items with ready_i high; expects n*3 gapless copies.
    task automatic burst(input string tag, input int n, input logic [31:0] base, input int id0);
        int item;
        int cp;
        bus.ready_i = 1'b1;
        drive(1'b1, base, 0);
        mid();
        chk({tag, ".acc.ready"}, 32'(bus.ready_o), 32'd1);
        chk({tag, ".acc.lock"},  32'(bus.lock_o),  32'd1);
        nxt();
        for (int j = 0; j < n * 3; j++) begin
            item = j / 3;
            cp   = j % 3;
            drive(item < n - 1, base + 32'(item + 1), (item + 1) % 4);
            mid();
            chk_out(tag, 1'b1, cp, (id0 + item) % 16, item % 4, base + 32'(item), 1'b1, cp == 2);
            nxt();
        end
        drive(1'b0, 32'h0, 0);
        mid();
        chk_out({tag, ".end"}, 1'b0, 0, (id0 + n - 1) % 16, (n - 1) % 4,
                base + 32'(n - 1), 1'b0, 1'b1);
        nxt();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b0;
        drive(1'b0, 32'h0, 0);
        nxt();

        // Reset state
        repeat (2) begin
            mid();
            chk_out("reset", 1'b0, 0, 0, 0, 32'h0, 1'b0, 1'b0);
            nxt();
        end
        rst = 1'b0;

        // Single item
        bus.ready_i = 1'b1;
        drive(1'b1, 32'hA5A5_0001, 2);
        mid();
        chk_out("single.acc", 1'b0, 0, 0, 0, 32'h0, 1'b1, 1'b1);
        nxt();
        drive(1'b0, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk_out("single.copy", 1'b1, k, 0, 2, 32'hA5A5_0001, 1'b1, k == 2);
            nxt();
        end
        mid();
        chk_out("single.end", 1'b0, 0, 0, 2, 32'hA5A5_0001, 1'b0, 1'b1);
        nxt();

        // Flush while idle clears id counter and blocks ready
        bus.flush_i = 1'b1;
        drive(1'b1, 32'h0, 0);
        mid();
        chk_out("flush1", 1'b0, 0, 0, 2, 32'hA5A5_0001, 1'b0, 1'b0);
        nxt();
        bus.flush_i = 1'b0;

        burst("b2b", 4, 32'h1000_0000, 0);

        bus.flush_i = 1'b1;
        mid();
        chk_out("flush2", 1'b0, 0, 3, 3, 32'h1000_0003, 1'b0, 1'b0);
        nxt();
        bus.flush_i = 1'b0;

        // 17 items: ids 0..15 then wrap to 0
        burst("wrap", 17, 32'h2000_0000, 0);

        // Stall during copy 1
        bus.ready_i = 1'b1;
        drive(1'b1, 32'hDEAD_0005, 1);
        mid();
        chk_out("stall.acc", 1'b0, 0, 0, 0, 32'h2000_0010, 1'b1, 1'b1);
        nxt();
        drive(1'b0, 32'h0, 0);
        mid();
        chk_out("stall.c0", 1'b1, 0, 1, 1, 32'hDEAD_0005, 1'b1, 1'b0);
        nxt();
        bus.ready_i = 1'b0;
        repeat (5) begin
            mid();
            chk_out("stall.hold", 1'b1, 1, 1, 1, 32'hDEAD_0005, 1'b1, 1'b0);
            nxt();
        end
        bus.ready_i = 1'b1;
        mid();
        chk_out("stall.c1", 1'b1, 1, 1, 1, 32'hDEAD_0005, 1'b1, 1'b0);
        nxt();
        mid();
        chk_out("stall.c2", 1'b1, 2, 1, 1, 32'hDEAD_0005, 1'b1, 1'b1);
        nxt();
        mid();
        chk_out("stall.end", 1'b0, 0, 1, 1, 32'hDEAD_0005, 1'b0, 1'b1);
        nxt();

        // Flush mid-replay
        drive(1'b1, 32'hCAFE_0007, 3);
        mid();
        chk_out("fl.acc", 1'b0, 0, 1, 1, 32'hDEAD_0005, 1'b1, 1'b1);
        nxt();
        drive(1'b0, 32'h0, 0);
        mid();
        chk_out("fl.c0", 1'b1, 0, 2, 3, 32'hCAFE_0007, 1'b1, 1'b0);
        nxt();
        bus.flush_i = 1'b1;
        drive(1'b1, 32'h1111_1111, 0);
        mid();
        chk_out("fl.flush", 1'b1, 1, 2, 3, 32'hCAFE_0007, 1'b1, 1'b0);
        nxt();
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 0);
        mid();
        chk_out("fl.after", 1'b0, 0, 2, 3, 32'hCAFE_0007, 1'b0, 1'b1);
        nxt();
        drive(1'b1, 32'h0BAD_F00D, 2);
        mid();
        chk_out("fl.acc2", 1'b0, 0, 2, 3, 32'hCAFE_0007, 1'b1, 1'b1);
        nxt();
        drive(1'b0, 32'h0, 0);
        mid();
        chk_out("fl.new.c0", 1'b1, 0, 0, 2, 32'h0BAD_F00D, 1'b1, 1'b0);
        nxt();
        mid();
        chk_out("fl.new.c1", 1'b1, 1, 0, 2, 32'h0BAD_F00D, 1'b1, 1'b0);
        nxt();

        // Reset during copy 2
        rst = 1'b1;
        drive(1'b1, 32'h7777_7777, 1);
        repeat (2) begin
            mid();
            chk_out("rst2", 1'b0, 0, 0, 0, 32'h0, 1'b0, 1'b0);
            nxt();
        end
        rst = 1'b0;
        drive(1'b0, 32'h0, 0);
        repeat (2) begin
            mid();
            chk_out("rst2.after", 1'b0, 0, 0, 0, 32'h0, 1'b0, 1'b1);
            nxt();
        end
        drive(1'b1, 32'h0000_0005, 1);
        mid();
        chk_out("rst2.acc", 1'b0, 0, 0, 0, 32'h0, 1'b1, 1'b1);
        nxt();
        drive(1'b0, 32'h0, 0);
        mid();
        chk_out("rst2.c0", 1'b1, 0, 0, 1, 32'h0000_0005, 1'b1, 1'b0);
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
